lsu_writeback: RTL
==================

// Module: lsu_writeback
// PURPOSE
// - Memory/writeback stage directly upstream of the register file in the NPC core.
// - Accepts one retired-execute op, performs at most one data-memory access (load/store) over a
//   valid/ready request + valid response bus, aligns/extends load data, then drives rd/rin/wen.
// - Emits a one-cycle commit pulse per instruction; this pulse gates the register file write strobe.
// PARAMETERS
// - DW  32  data width (matches `RegBus)
// - AW  32  data-memory address width
// PORTS
// - clk            in   1   core clock
// - rst            in   1   async reset, active-low (`RST_VAL = 1'b0)
// - ex_valid       in   1   execute stage presents an op
// - ex_ready       out  1   stage can accept (state==IDLE)
// - ex_rd          in   5   destination register
// - ex_wen         in   1   op writes rd
// - ex_is_load     in   1   op is LB/LH/LW/LBU/LHU
// - ex_is_store    in   1   op is SB/SH/SW (never set together with ex_is_load)
// - ex_funct3      in   3   RV32I funct3 of load/store
// - ex_result      in   DW  ALU result, or effective address for load/store
// - ex_store_data  in   DW  rs2 value for stores
// - mem_req_valid  out  1   request valid; held with payload stable until mem_req_ready
// - mem_req_ready  in   1   memory accepts request
// - mem_req_addr   out  AW  word-aligned address {addr[AW-1:2],2'b00}
// - mem_req_wen    out  1   1=store, 0=load
// - mem_req_wdata  out  DW  store data shifted into byte lanes
// - mem_req_wmask  out  4   byte-lane write mask (0 for loads)
// - mem_rsp_valid  in   1   read data / write ack valid (earliest: cycle after accept)
// - mem_rsp_rdata  in   DW  read word
// - rf_wen         out  1   register write enable (0 when rd==0)
// - rf_rd          out  5   register index
// - rf_rin         out  DW  write data
// - commit         out  1   one-cycle pulse, instruction retired
// BEHAVIOUR
// - FSM: IDLE, REQ, WAIT, WB. Reset -> IDLE; all registered outputs 0; ex_ready=1.
// - IDLE: on ex_valid&ex_ready latch op. Non-memory -> WB; load/store -> REQ.
// - REQ: mem_req_valid=1; on mem_req_ready -> WAIT. mem_rsp_valid outside WAIT is ignored.
// - WAIT: on mem_rsp_valid latch rdata -> WB. No timeout.
// - WB (exactly 1 cycle): commit=1; rf_wen=ex_wen&(rd!=0) (stores: rf_wen=0); -> IDLE.
// - Latency: ALU op accept->commit 1 cycle; memory op = 2 + req stall + rsp wait cycles.
// - Throughput: back-to-back ALU ops accepted every 2 cycles (ex_ready low in WB).
// - off=addr[1:0]. Store masks: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111; wdata<<(8*off).
// - Load: word>>(8*off), then LB/LH sign-extend, LBU/LHU zero-extend, LW as-is; funct3 3/6/7 -> 0.
// - Outputs rf_* and commit are 0 outside WB.
// - Async reset mid-transaction: immediate IDLE, request dropped; memory side reset together.
// CONFIGURATION
// - LSU_MISALIGN_CHECK_EN defined: LH/LHU/SH with off[0]=1, LW/SW with off!=0 issue no request;
//   go IDLE->WB directly, rf_wen=0, extra output misalign (1 bit) pulses with commit.
// - Undefined: no misalign port; access proceeds, mask bits shifted past lane 3 dropped,
//   load bytes beyond the word read as 0 before extension.
// STRUCTURE
// - vsrc/defines.v: state encodings, LSU funct3 codes (LB..LHU, SB..SW), `RegBus, `RST_VAL.
// - Sub-module load_align: combinational {rdata,off,funct3} -> extended DW result.
// TESTING
// - ALU op rd=5 result=0x1234_5678 -> next cycle rf_wen=1 rd=5 rin=0x12345678 commit=1.
// - ALU op rd=0 -> commit=1, rf_wen=0.
// - LB addr=0x8000_0003, rdata=0x80FF_0011 -> req addr 0x8000_0000, rin=0xFFFF_FF80.
// - SH addr=0x...02 data=0xABCD -> wmask=4'b1100, wdata=0xABCD_0000, commit, rf_wen=0.
// - mem_req_ready low 3 cycles -> valid/addr/wdata stable, single accept, single commit.
// - rst low during WAIT -> next edge IDLE, outputs 0; with _EN, LW addr=...1 -> misalign=1, no req.

Source files
------------

// File: rtl/lsu_writeback_pkg.sv
// Shared types, widths and helpers for the lsu_writeback memory/writeback stage.
package lsu_writeback_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned MW = 4;
  localparam int unsigned FW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // RV32I load/store funct3 encodings
  localparam logic [FW-1:0] F3_LB  = 3'b000;
  localparam logic [FW-1:0] F3_LH  = 3'b001;
  localparam logic [FW-1:0] F3_LW  = 3'b010;
  localparam logic [FW-1:0] F3_LBU = 3'b100;
  localparam logic [FW-1:0] F3_LHU = 3'b101;
  localparam logic [FW-1:0] F3_SB  = 3'b000;
  localparam logic [FW-1:0] F3_SH  = 3'b001;
  localparam logic [FW-1:0] F3_SW  = 3'b010;

  // Memory request payload as held on the request bus
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } mem_req_t;

  // Fields of the in-flight op kept after acceptance
  typedef struct packed {
    logic [RW-1:0] rd;
    logic          wen;
    logic          is_store;
    logic [FW-1:0] funct3;
    logic [1:0]    off;
  } op_t;

  // Byte-lane mask; lanes shifted past lane 3 fall off the 4-bit result
  function automatic logic [MW-1:0] store_mask(input logic [FW-1:0] funct3,
                                               input logic [1:0]    off);
    logic [MW-1:0] m;
    case (funct3)
      F3_SB:   m = MW'(4'b0001 << off);
      F3_SH:   m = MW'(4'b0011 << off);
      F3_SW:   m = 4'b1111;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Halfword needs even offset, word needs offset 0 (same test for loads and stores)
  function automatic logic is_misaligned(input logic [FW-1:0] funct3,
                                         input logic [1:0]    off);
    logic r;
    case (funct3[1:0])
      2'b01:   r = off[0];
      2'b10:   r = (off != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_writeback_if.sv
// Execute->LSU op bus and LSU->data-memory request/response bus.
interface lsu_ex_if;
  import lsu_writeback_pkg::*;

  logic          ex_valid;
  logic          ex_ready;
  logic [RW-1:0] ex_rd;
  logic          ex_wen;
  logic          ex_is_load;
  logic          ex_is_store;
  logic [FW-1:0] ex_funct3;
  logic [DW-1:0] ex_result;
  logic [DW-1:0] ex_store_data;

  modport master (
    output ex_valid, ex_rd, ex_wen, ex_is_load, ex_is_store, ex_funct3, ex_result, ex_store_data,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_rd, ex_wen, ex_is_load, ex_is_store, ex_funct3, ex_result, ex_store_data,
    output ex_ready
  );
endinterface

interface lsu_mem_if;
  import lsu_writeback_pkg::*;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_wen;
  logic [DW-1:0] mem_req_wdata;
  logic [MW-1:0] mem_req_wmask;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_writeback_load_align.sv
// Combinational load alignment: shift the read word down by the byte offset, then extend.
module lsu_writeback_load_align
  import lsu_writeback_pkg::*;
(
  input  logic [DW-1:0] rdata_i,
  input  logic [1:0]    off_i,
  input  logic [FW-1:0] funct3_i,
  output logic [DW-1:0] result_c_o
);

  logic [DW-1:0] shifted_c;

  // Bytes above the word read as zero before extension
  assign shifted_c = DW'(rdata_i >> {off_i, 3'b000});

  // Extension by load type; unused funct3 codes yield zero
  always_comb begin
    result_c_o = '0;
    case (funct3_i)
      F3_LB:   result_c_o = {{(DW-8){shifted_c[7]}}, shifted_c[7:0]};
      F3_LH:   result_c_o = {{(DW-16){shifted_c[15]}}, shifted_c[15:0]};
      F3_LW:   result_c_o = shifted_c;
      F3_LBU:  result_c_o = {{(DW-8){1'b0}}, shifted_c[7:0]};
      F3_LHU:  result_c_o = {{(DW-16){1'b0}}, shifted_c[15:0]};
      default: result_c_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_writeback.sv
// Memory/writeback stage: accepts one op, performs at most one data-memory access,
// then drives the register-file write port together with a one-cycle commit pulse.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned accesses skip memory and
// raise misalign_o alongside commit).
module lsu_writeback
  import lsu_writeback_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  lsu_ex_if.slave       ex_if,
  lsu_mem_if.master     mem_if,
  output logic          rf_wen_o,
  output logic [RW-1:0] rf_rd_o,
  output logic [DW-1:0] rf_rin_o,
  output logic          commit_o
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic          misalign_o
`endif
);

  state_e        state_q, state_d;
  op_t           op_q, op_d;
  mem_req_t      req_q, req_d;
  logic          req_valid_q, req_valid_d;
  logic          ex_ready_q, ex_ready_d;
  logic          rf_wen_q, rf_wen_d;
  logic [RW-1:0] rf_rd_q, rf_rd_d;
  logic [DW-1:0] rf_rin_q, rf_rin_d;
  logic          commit_q, commit_d;
`ifdef LSU_MISALIGN_CHECK_EN
  logic          misalign_q, misalign_d;
`endif

  logic [1:0]    off_c;
  logic          is_mem_c;
  logic          mis_c;
  logic [DW-1:0] load_data_c;

  assign off_c    = ex_if.ex_result[1:0];
  assign is_mem_c = ex_if.ex_is_load | ex_if.ex_is_store;

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis_c = is_mem_c & is_misaligned(ex_if.ex_funct3, off_c);
`else
  assign mis_c = 1'b0;
`endif

  lsu_writeback_load_align u_load_align (
    .rdata_i    (mem_if.mem_rsp_rdata),
    .off_i      (op_q.off),
    .funct3_i   (op_q.funct3),
    .result_c_o (load_data_c)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    req_d       = req_q;
    req_valid_d = req_valid_q;
    rf_wen_d    = 1'b0;
    rf_rd_d     = '0;
    rf_rin_d    = '0;
    commit_d    = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    misalign_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ex_if.ex_valid) begin
          op_d.rd       = ex_if.ex_rd;
          op_d.wen      = ex_if.ex_wen;
          op_d.is_store = ex_if.ex_is_store;
          op_d.funct3   = ex_if.ex_funct3;
          op_d.off      = off_c;
          if (!is_mem_c || mis_c) begin
            state_d  = ST_WB;
            commit_d = 1'b1;
            rf_rd_d  = ex_if.ex_rd;
            rf_wen_d = ex_if.ex_wen && (ex_if.ex_rd != '0) && !is_mem_c;
            rf_rin_d = is_mem_c ? '0 : ex_if.ex_result;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_d = mis_c;
`endif
          end else begin
            state_d     = ST_REQ;
            req_valid_d = 1'b1;
            req_d.addr  = {ex_if.ex_result[AW-1:2], 2'b00};
            req_d.wen   = ex_if.ex_is_store;
            req_d.wdata = ex_if.ex_is_store ? DW'(ex_if.ex_store_data << {off_c, 3'b000}) : '0;
            req_d.wmask = ex_if.ex_is_store ? store_mask(ex_if.ex_funct3, off_c) : '0;
          end
        end
      end
      ST_REQ: begin
        if (mem_if.mem_req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
          req_d       = '0;
        end
      end
      ST_WAIT: begin
        if (mem_if.mem_rsp_valid) begin
          state_d  = ST_WB;
          commit_d = 1'b1;
          rf_rd_d  = op_q.rd;
          rf_wen_d = op_q.wen && !op_q.is_store && (op_q.rd != '0);
          rf_rin_d = op_q.is_store ? '0 : load_data_c;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ex_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      ex_ready_q  <= 1'b1;
      rf_wen_q    <= 1'b0;
      rf_rd_q     <= '0;
      rf_rin_q    <= '0;
      commit_q    <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      ex_ready_q  <= ex_ready_d;
      rf_wen_q    <= rf_wen_d;
      rf_rd_q     <= rf_rd_d;
      rf_rin_q    <= rf_rin_d;
      commit_q    <= commit_d;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign ex_if.ex_ready       = ex_ready_q;
  assign mem_if.mem_req_valid = req_valid_q;
  assign mem_if.mem_req_addr  = req_q.addr;
  assign mem_if.mem_req_wen   = req_q.wen;
  assign mem_if.mem_req_wdata = req_q.wdata;
  assign mem_if.mem_req_wmask = req_q.wmask;
  assign rf_wen_o             = rf_wen_q;
  assign rf_rd_o              = rf_rd_q;
  assign rf_rin_o             = rf_rin_q;
  assign commit_o             = commit_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_o           = misalign_q;
`endif

endmodule
